// File: rtl/imm_encoder.sv
// Sequential inverse of InmExtension: searches for the 24-bit immediate field
// that expands back to a given 32-bit constant, or reports that none exists.
module imm_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] value,
  input  logic [1:0]  InmSrc,
  output logic        busy,
  output logic        done,
  output logic        ok,
  output logic [23:0] Instr
);

  typedef enum logic [1:0] {IDLE, SEARCH, CHECK} stateT;

  stateT       stateReg, stateNext;
  logic [3:0]  rotReg, rotNext;
  logic [31:0] valueReg, valueNext;
  logic [1:0]  srcReg, srcNext;
  logic        doneNext, okNext;
  logic [23:0] instrNext;
  logic [5:0]  shiftAmt;
  logic [31:0] cand;
  logic        fitsMem, fitsBranch;

  // Rotating the constant left by 2r undoes the ROR applied during extension;
  // a right shift by 32 yields zero, so r=0 needs no special case.
  assign shiftAmt = {1'b0, rotReg, 1'b0};
  assign cand     = (valueReg << shiftAmt) | (valueReg >> (6'd32 - shiftAmt));

  assign fitsMem    = (valueReg[31:12] == 20'h0);
  assign fitsBranch = (valueReg[1:0] == 2'b00) && (valueReg[31:25] == {7{valueReg[25]}});

  assign busy = (stateReg != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg <= IDLE;
      rotReg   <= 4'd0;
      valueReg <= 32'h0;
      srcReg   <= 2'b00;
      done     <= 1'b0;
      ok       <= 1'b0;
      Instr    <= 24'h0;
    end else begin
      stateReg <= stateNext;
      rotReg   <= rotNext;
      valueReg <= valueNext;
      srcReg   <= srcNext;
      done     <= doneNext;
      ok       <= okNext;
      Instr    <= instrNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    rotNext   = rotReg;
    valueNext = valueReg;
    srcNext   = srcReg;
    doneNext  = 1'b0;
    okNext    = ok;
    instrNext = Instr;
    unique case (stateReg)
      IDLE: begin
        if (start) begin
          valueNext = value;
          srcNext   = InmSrc;
          rotNext   = 4'd0;
          stateNext = (InmSrc == 2'b00) ? SEARCH : CHECK;
        end
      end
      SEARCH: begin
        if (cand[31:8] == 24'h0) begin
          doneNext  = 1'b1;
          okNext    = 1'b1;
          instrNext = {12'h0, rotReg, cand[7:0]};
          stateNext = IDLE;
        end else if (rotReg == 4'd15) begin
          doneNext  = 1'b1;
          okNext    = 1'b0;
          instrNext = 24'h0;
          stateNext = IDLE;
        end else begin
          rotNext = rotReg + 4'd1;
        end
      end
      CHECK: begin
        doneNext  = 1'b1;
        stateNext = IDLE;
        okNext    = 1'b0;
        instrNext = 24'h0;
        if (srcReg == 2'b01 && fitsMem) begin
          okNext    = 1'b1;
          instrNext = {12'h0, valueReg[11:0]};
        end else if (srcReg == 2'b10 && fitsBranch) begin
          okNext    = 1'b1;
          instrNext = valueReg[25:2];
        end
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed cases, control corner cases and
// randomized requests checked against a forward-extension reference model.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] value;
  logic [1:0]  InmSrc;
  logic        busy, done, ok;
  logic [23:0] Instr;

  int checks = 0;
  int errors = 0;

  imm_encoder dut (
    .clk(clk), .reset(reset), .start(start), .value(value), .InmSrc(InmSrc),
    .busy(busy), .done(done), .ok(ok), .Instr(Instr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Forward model of InmExtension.
  function automatic logic [31:0] extend(input logic [23:0] f, input logic [1:0] s);
    logic [31:0] x;
    int sh;
    case (s)
      2'b00: begin
        x  = {24'h0, f[7:0]};
        sh = 2 * int'(f[11:8]);
        return (x >> sh) | (x << (32 - sh));
      end
      2'b01:   return {20'h0, f[11:0]};
      2'b10:   return {{6{f[23]}}, f, 2'b00};
      default: return 32'h0;
    endcase
  endfunction

  // Reference: exhaustive search over (rotation, imm8) for class 00, range checks otherwise.
  task automatic model(input logic [31:0] v, input logic [1:0] s,
                       output logic okE, output logic [23:0] instrE, output int latE);
    int sv;
    okE = 1'b0; instrE = 24'h0; latE = 1;
    case (s)
      2'b00: begin
        latE = 16;
        for (int rot = 0; rot < 16 && !okE; rot++)
          for (int imm = 0; imm < 256 && !okE; imm++)
            if (extend(24'((rot << 8) | imm), 2'b00) == v) begin
              okE = 1'b1; instrE = 24'((rot << 8) | imm); latE = rot + 1;
            end
      end
      2'b01: if (v < 32'd4096) begin okE = 1'b1; instrE = 24'(v); end
      2'b10: begin
        sv = int'(v);
        if (v % 4 == 0 && sv >= -(1 << 25) && sv <= (1 << 25) - 4) begin
          okE = 1'b1; instrE = 24'((v >> 2) & 32'hFFFFFF);
        end
      end
      default: ;
    endcase
  endtask

  // Issues one request from an idle DUT (called 1 time unit after a rising edge).
  task automatic doRequest(input logic [31:0] v, input logic [1:0] s,
                           output logic okO, output logic [23:0] instrO, output int lat);
    start = 1'b1; value = v; InmSrc = s;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
      check("busy_while_working", busy, 1'b1);
    end
    check("done_seen", done, 1'b1);
    check("busy_at_done", busy, 1'b0);
    okO = ok; instrO = Instr;
    $display("txn src=%0d value=%h ok=%0d Instr=%h latency=%0d", s, v, okO, instrO, lat);
  endtask

  task automatic runAndCompare(input string tag, input logic [31:0] v, input logic [1:0] s);
    logic okE, okO;
    logic [23:0] instrE, instrO;
    int latE, latO;
    model(v, s, okE, instrE, latE);
    doRequest(v, s, okO, instrO, latO);
    check({tag, "_ok"}, okO, okE);
    check({tag, "_instr"}, instrO, instrE);
    check({tag, "_latency"}, latO, latE);
    if (okO) check({tag, "_roundtrip"}, extend(instrO, s), v);
  endtask

  initial begin
    logic [31:0] rv;
    logic [1:0]  rs;
    int cyc, doneCount;

    reset = 1'b1; start = 1'b0; value = 32'h0; InmSrc = 2'b00;
    #12;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_ok", ok, 1'b0);
    check("reset_instr", Instr, 24'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    runAndCompare("c00_ff", 32'h000000FF, 2'b00);
    check("c00_ff_instr_const", Instr, 24'h0000FF);
    @(posedge clk); #1;
    check("done_drops", done, 1'b0);
    runAndCompare("c00_ff000000", 32'hFF000000, 2'b00);
    check("c00_ff000000_const", Instr, 24'h0004FF);
    runAndCompare("c00_101", 32'h00000101, 2'b00);
    runAndCompare("c10_neg", 32'hFFFFFFF8, 2'b10);
    check("c10_neg_const", Instr, 24'hFFFFFE);
    runAndCompare("c10_unaligned", 32'h00000006, 2'b10);
    runAndCompare("c01_max", 32'h00000FFF, 2'b01);
    check("c01_max_const", Instr, 24'h000FFF);
    runAndCompare("c01_over", 32'h00001000, 2'b01);
    runAndCompare("c11_any", 32'h00000004, 2'b11);
    runAndCompare("c10_toobig", 32'h02000000, 2'b10);

    // Start while busy is ignored
    start = 1'b1; value = 32'h00000101; InmSrc = 2'b00;
    @(posedge clk); #1;
    start = 1'b0; cyc = 0;
    repeat (2) begin @(posedge clk); #1; cyc++; end
    start = 1'b1; value = 32'h000000FF; InmSrc = 2'b01;
    @(posedge clk); #1; cyc++;
    start = 1'b0;
    while (!done && cyc < 40) begin @(posedge clk); #1; cyc++; end
    check("ignore_latency", cyc, 16);
    check("ignore_ok", ok, 1'b0);
    check("ignore_instr", Instr, 24'h0);
    doneCount = 0;
    repeat (4) begin @(posedge clk); #1; if (done) doneCount++; end
    check("ignore_no_extra_done", doneCount, 0);

    // Back-to-back with start held high
    start = 1'b1; value = 32'h00000123; InmSrc = 2'b01;
    @(posedge clk); #1;
    value = 32'h00000456;
    @(posedge clk); #1;
    check("b2b_first_done", done, 1'b1);
    check("b2b_first_instr", Instr, 24'h000123);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_second_busy", busy, 1'b1);
    check("b2b_second_done_low", done, 1'b0);
    @(posedge clk); #1;
    check("b2b_second_done", done, 1'b1);
    check("b2b_second_instr", Instr, 24'h000456);

    // Asynchronous reset aborts a SEARCH at cycle 3
    start = 1'b1; value = 32'h00000101; InmSrc = 2'b00;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2 reset = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_ok", ok, 1'b0);
    check("abort_instr", Instr, 24'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    doneCount = 0;
    repeat (20) begin @(posedge clk); #1; if (done || busy) doneCount++; end
    check("abort_no_done", doneCount, 0);

    // Randomized requests, biased toward encodable values
    for (int i = 0; i < 40; i++) begin
      rs = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0: rv = $urandom;
        1: begin
          rv = $urandom_range(0, 255);
          rv = (rv >> (2 * (i % 16))) | (rv << (32 - 2 * (i % 16)));
        end
        default: rv = (rs == 2'b10) ? 32'($signed($urandom_range(0, 1 << 20)) - (1 << 19)) << 2
                                    : $urandom_range(0, 8191);
      endcase
      runAndCompare("rand", rv, rs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
